// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush, dmem wait freeze
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_nop,
  input  logic        ex_take,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state, nxt_state, ret_state, nxt_ret;
  logic [2:0] lcnt, nxt_lcnt;
  logic [7:0] wait_cnt, nxt_wait_cnt;
  logic       load_use, take, mem_wait;
  logic       freeze, stall, flush, set_err;

  assign load_use = ex_load & ~ex_nop & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign take     = ex_take & ~ex_nop;
  assign mem_wait = dmem_req & ~dmem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= RUN;
      ret_state <= RUN;
      lcnt      <= 3'd0;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      ret_state <= nxt_ret;
      lcnt      <= nxt_lcnt;
      wait_cnt  <= nxt_wait_cnt;
      if (set_err) mem_err <= 1'b1;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    nxt_ret      = ret_state;
    nxt_lcnt     = lcnt;
    nxt_wait_cnt = wait_cnt;
    freeze       = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    set_err      = 1'b0;
    case (cur_state)
      RUN: begin
        if (mem_wait) begin
          freeze       = 1'b1;
          nxt_state    = MEM_WAIT;
          nxt_ret      = RUN;
          nxt_wait_cnt = 8'd0;
        end else if (take) begin
          flush = 1'b1;
        end else if (load_use) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            nxt_state = LOAD_STALL;
            nxt_lcnt  = LCNT_INIT;
          end
        end
      end
      LOAD_STALL: begin
        // lcnt is left untouched across a memory freeze so the stall resumes where it paused
        if (mem_wait) begin
          freeze       = 1'b1;
          nxt_state    = MEM_WAIT;
          nxt_ret      = LOAD_STALL;
          nxt_wait_cnt = 8'd0;
        end else begin
          stall    = 1'b1;
          nxt_lcnt = lcnt - 3'd1;
          if (lcnt <= 3'd1) nxt_state = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          nxt_state = ret_state;
        end else if (wait_cnt >= WAIT_LAST) begin
          set_err   = 1'b1;
          nxt_state = ret_state;
        end else begin
          freeze = 1'b1;
          if (wait_cnt != 8'hFF) nxt_wait_cnt = wait_cnt + 8'd1;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // Controls are forced low while reset is asserted so an abort is visible immediately
  assign pc_hold      = reset & (freeze | stall);
  assign if_id_hold   = reset & (freeze | stall);
  assign if_id_flush  = reset & flush;
  assign id_ex_bubble = reset & (stall | flush);
  assign id_ex_hold   = reset & freeze;
  assign ex_mem_hold  = reset & freeze;
  assign state        = cur_state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_hold && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with LOAD_LAT=3, MEM_TIMEOUT=4
module tb_hazard_ctrl;
  localparam int LL = 3;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_load = 0, ex_nop = 0, ex_take = 0;
  logic        dmem_req = 0, dmem_ack = 0;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.LOAD_LAT(LL), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_nop(ex_nop), .ex_take(ex_take),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bubble cycles, whether a memory wait is in progress and how long it has lasted
  int m_bubbles = 0, m_waited = 0, m_sc = 0, m_fc = 0;
  bit m_waiting = 0, m_err = 0;

  initial begin
    int  n_bubbles, n_waited, n_sc, n_fc;
    bit  n_waiting, n_err, lu, tk, frz, stl, fl;
    logic [1:0]  e_state;
    logic [31:0] e_sc, e_fc;
    forever begin
      @(negedge clk);
      frz = 0; stl = 0; fl = 0;
      n_bubbles = m_bubbles; n_waited = m_waited; n_waiting = m_waiting; n_err = m_err;
      n_sc = m_sc; n_fc = m_fc;
      if (!reset) begin
        e_state = 2'd0;
      end else begin
        lu = ex_load && !ex_nop && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        tk = ex_take && !ex_nop;
        e_state = m_waiting ? 2'd2 : (m_bubbles > 0 ? 2'd1 : 2'd0);
        if (m_waiting) begin
          if (dmem_ack) n_waiting = 0;
          else if (m_waited == MT - 1) begin n_waiting = 0; n_err = 1; end
          else begin frz = 1; n_waited = m_waited + 1; end
        end else if (dmem_req && !dmem_ack) begin
          frz = 1; n_waiting = 1; n_waited = 0;
        end else if (m_bubbles > 0) begin
          stl = 1; n_bubbles = m_bubbles - 1;
        end else if (tk) begin
          fl = 1;
        end else if (lu) begin
          stl = 1; n_bubbles = LL - 1;
        end
        if (frz || stl) n_sc = m_sc + 1;
        if (fl) n_fc = m_fc + 1;
      end
`ifdef HAZARD_PERF_CNT_EN
      e_sc = 32'(m_sc); e_fc = 32'(m_fc);
`else
      e_sc = 32'd0; e_fc = 32'd0;
`endif
      chk("m_pc_hold", pc_hold, frz | stl);
      chk("m_if_id_hold", if_id_hold, frz | stl);
      chk("m_if_id_flush", if_id_flush, fl);
      chk("m_id_ex_bubble", id_ex_bubble, stl | fl);
      chk("m_id_ex_hold", id_ex_hold, frz);
      chk("m_ex_mem_hold", ex_mem_hold, frz);
      chk("m_mem_err", mem_err, reset ? m_err : 1'b0);
      chk("m_state", state, e_state);
      chk("m_stall_cnt", stall_cnt, reset ? e_sc : 32'd0);
      chk("m_flush_cnt", flush_cnt, reset ? e_fc : 32'd0);
      @(posedge clk);
      if (!reset) begin
        m_bubbles = 0; m_waited = 0; m_waiting = 0; m_err = 0; m_sc = 0; m_fc = 0;
      end else begin
        m_bubbles = n_bubbles; m_waited = n_waited; m_waiting = n_waiting; m_err = n_err;
        m_sc = n_sc; m_fc = n_fc;
      end
    end
  end

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic ld, input logic nop, input logic tk,
                        input logic rq, input logic ak);
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_rd = rd; ex_load = ld; ex_nop = nop; ex_take = tk; dmem_req = rq; dmem_ack = ak;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    #2 reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // load-use on rs1, three bubble cycles
    set_in(5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    #2 chk("lu0_pc_hold", pc_hold, 1); chk("lu0_state", state, 0);
    tick();
    #2 chk("lu1_state", state, 1); chk("lu1_bubble", id_ex_bubble, 1);
    tick();
    #2 chk("lu2_state", state, 1); chk("lu2_if_id_hold", if_id_hold, 1);
    tick();
    idle();
    #2 chk("lu3_state", state, 0); chk("lu3_pc_hold", pc_hold, 0);
    tick();

    // rd=x0 never stalls
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    #2 chk("x0_pc_hold", pc_hold, 0);
    tick();
    // rs2 hazard, and a load bubble in EX
    set_in(3, 0, 7, 1, 7, 1, 0, 0, 0, 0);
    repeat (3) tick();
    set_in(7, 1, 0, 0, 7, 1, 1, 0, 0, 0);
    #2 chk("nop_pc_hold", pc_hold, 0);
    tick();

    // redirect
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2 chk("tk_flush", if_id_flush, 1); chk("tk_bubble", id_ex_bubble, 1); chk("tk_pc_hold", pc_hold, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    #2 chk("tknop_flush", if_id_flush, 0);
    tick();
    // take beats load_use
    set_in(5, 1, 0, 0, 5, 1, 0, 1, 0, 0);
    #2 chk("tklu_flush", if_id_flush, 1); chk("tklu_pc_hold", pc_hold, 0);
    tick();
    idle();
    #2 chk("tklu_state", state, 0);
    tick();

    // wait beats take and load_use
    set_in(5, 1, 0, 0, 5, 1, 0, 1, 1, 0);
    #2 chk("pri_pc_hold", pc_hold, 1); chk("pri_ex_mem_hold", ex_mem_hold, 1);
    chk("pri_flush", if_id_flush, 0); chk("pri_bubble", id_ex_bubble, 0);
    tick();
    set_in(5, 1, 0, 0, 5, 1, 0, 1, 1, 1);
    #2 chk("pri_state", state, 2); chk("pri_ack_hold", pc_hold, 0); chk("pri_ack_flush", if_id_flush, 0);
    tick();
    idle();
    #2 chk("pri_back", state, 0);
    tick();

    // ack in the request cycle: no freeze
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 chk("fast_hold", pc_hold, 0);
    tick();
    idle();
    #2 chk("fast_state", state, 0);
    tick();

    // wait raised in the second LOAD_STALL cycle
    set_in(5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("ws_state0", state, 1); chk("ws_id_ex_hold", id_ex_hold, 1); chk("ws_bubble", id_ex_bubble, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #2 chk("ws_wait_state", state, 2); chk("ws_wait_hold", pc_hold, 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 chk("ws_ack_hold", pc_hold, 0);
    tick();
    idle();
    #2 chk("ws_resume_state", state, 1); chk("ws_resume_hold", pc_hold, 1);
    tick();
    #2 chk("ws_done_state", state, 0); chk("ws_done_hold", pc_hold, 0);
    tick();

    // timeout
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("to_entry_hold", pc_hold, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #2 chk("to_freeze", ex_mem_hold, 1); chk("to_err_low", mem_err, 0);
      tick();
    end
    #2 chk("to_release_state", state, 2); chk("to_release_hold", pc_hold, 0); chk("to_err_pre", mem_err, 0);
    tick();
    idle();
    #2 chk("to_err_set", mem_err, 1); chk("to_back", state, 0);
    repeat (3) tick();
    #2 chk("to_err_sticky", mem_err, 1);

    // asynchronous reset in MEM_WAIT
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_mem_err", mem_err, 0);
    chk("ar_pc_hold", pc_hold, 0);
    chk("ar_id_ex_hold", id_ex_hold, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_flush_cnt", flush_cnt, 0);
    tick();
    idle();
    reset = 1'b1;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
